// File: rtl/spi_port_arbiter.sv
// spi_port_arbiter
// ----------------
// Shares the SPI client's 8-bit register port (A/D/nRD/nWR) between two bus
// requesters (r0 = host CPU bridge, r1 = packet DMA engine). Each access is
// sequenced as SETUP -> STROBE (STROBE_CYC cycles) -> RECOVER (RECOVER_CYC
// cycles). When nobody is asking for the port, the status register at
// address 1 is read every POLL_DIV idle cycles and mirrored on status_o.
//
// Ports
//   busclk_i, reset_i          clock and synchronous active-high reset
//   rN_req_i/wr_i/addr_i/
//   rN_wdata_i/lock_i          requester N access request (held until done)
//   rN_gnt_o                   requester N owns the port (SETUP..RECOVER)
//   rN_done_o                  one-cycle completion pulse
//   rN_rdata_o                 last read data returned to requester N
//   spi_A_o/spi_D_o            address / write data to the SPI client
//   spi_D_i                    read data from the SPI client
//   spi_nRD_o/spi_nWR_o        active-low strobes
//   status_o/status_chg_o      polled status shadow and its change pulse
//
// All outputs are registered so the strobes and address lines toggle
// cleanly off the clock edge.

module spi_port_arbiter #(
    parameter int STROBE_CYC  = 2,
    parameter int RECOVER_CYC = 1,
    parameter int POLL_DIV    = 64
) (
    input  logic       busclk_i,
    input  logic       reset_i,

    input  logic       r0_req_i,
    input  logic       r0_wr_i,
    input  logic [3:0] r0_addr_i,
    input  logic [7:0] r0_wdata_i,
    input  logic       r0_lock_i,
    output logic       r0_gnt_o,
    output logic       r0_done_o,
    output logic [7:0] r0_rdata_o,

    input  logic       r1_req_i,
    input  logic       r1_wr_i,
    input  logic [3:0] r1_addr_i,
    input  logic [7:0] r1_wdata_i,
    input  logic       r1_lock_i,
    output logic       r1_gnt_o,
    output logic       r1_done_o,
    output logic [7:0] r1_rdata_o,

    output logic [3:0] spi_A_o,
    output logic [7:0] spi_D_o,
    input  logic [7:0] spi_D_i,
    output logic       spi_nRD_o,
    output logic       spi_nWR_o,

    output logic [7:0] status_o,
    output logic       status_chg_o
);

    localparam int PCW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [PCW-1:0] POLL_LAST = (POLL_DIV > 0) ? PCW'(POLL_DIV - 1) : '0;
    localparam bit POLL_EN = (POLL_DIV != 0);
    localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;
    typedef enum logic [1:0] {OWN_R0, OWN_R1, OWN_POLL} owner_t;

    state_t         state_q, state_d;
    owner_t         owner_q, owner_d;
    logic [3:0]     phaseCnt_q, phaseCnt_d;
    logic [PCW-1:0] pollCnt_q, pollCnt_d;
    logic           lastR1_q, lastR1_d;

    logic [3:0] spiA_q;
    logic [7:0] spiD_q;
    logic       isWr_q;
    logic       nRd_q, nWr_q;
    logic       gnt0_q, gnt1_q;
    logic       done0_q, done1_q;
    logic [7:0] rdata0_q, rdata1_q;
    logic [7:0] status_q;
    logic       statusChg_q;

    logic [3:0] selAddr;
    logic [7:0] selData;
    logic       selWr;
    logic       strobeLast;
    logic       ownerHolds;

    // The read capture happens on the edge that leaves the last strobe
    // cycle, so done/rdata/status appear in the first RECOVER cycle.
    assign strobeLast = (state_q == STROBE) && (phaseCnt_q == STROBE_LAST);

    // A locked owner that still requests keeps the port without re-arbitration.
    assign ownerHolds = ((owner_q == OWN_R0) && r0_lock_i && r0_req_i) ||
                        ((owner_q == OWN_R1) && r1_lock_i && r1_req_i);

    // Next-state logic: arbitration in IDLE, fixed-length phase counting
    // elsewhere. lastR1 records whether r1 was the last requester granted.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        phaseCnt_d = phaseCnt_q;
        pollCnt_d  = pollCnt_q;
        lastR1_d   = lastR1_q;
        case (state_q)
            IDLE: begin
                phaseCnt_d = 4'd0;
                if (r0_req_i || r1_req_i) begin
                    if (r0_req_i && r1_req_i) begin
                        owner_d = lastR1_q ? OWN_R0 : OWN_R1;
                    end else if (r0_req_i) begin
                        owner_d = OWN_R0;
                    end else begin
                        owner_d = OWN_R1;
                    end
                    lastR1_d  = (owner_d == OWN_R1);
                    pollCnt_d = '0;
                    state_d   = SETUP;
                end else if (POLL_EN && (pollCnt_q == POLL_LAST)) begin
                    owner_d   = OWN_POLL;
                    pollCnt_d = '0;
                    state_d   = SETUP;
                end else if (POLL_EN) begin
                    pollCnt_d = pollCnt_q + 1'b1;
                end
            end
            SETUP: begin
                phaseCnt_d = 4'd0;
                state_d    = STROBE;
            end
            STROBE: begin
                if (phaseCnt_q == STROBE_LAST) begin
                    phaseCnt_d = 4'd0;
                    state_d    = RECOVER;
                end else begin
                    phaseCnt_d = phaseCnt_q + 4'd1;
                end
            end
            RECOVER: begin
                if (phaseCnt_q == RECOVER_LAST) begin
                    phaseCnt_d = 4'd0;
                    state_d    = ownerHolds ? SETUP : IDLE;
                end else begin
                    phaseCnt_d = phaseCnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/data/direction of whoever will own the next access; the poller
    // always reads address 1 and drives zero data.
    always_comb begin
        selAddr = 4'd1;
        selData = 8'h00;
        selWr   = 1'b0;
        case (owner_d)
            OWN_R0: begin
                selAddr = r0_addr_i;
                selData = r0_wdata_i;
                selWr   = r0_wr_i;
            end
            OWN_R1: begin
                selAddr = r1_addr_i;
                selData = r1_wdata_i;
                selWr   = r1_wr_i;
            end
            default: ;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge busclk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            owner_q    <= OWN_R0;
            phaseCnt_q <= 4'd0;
            pollCnt_q  <= '0;
            lastR1_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            phaseCnt_q <= phaseCnt_d;
            pollCnt_q  <= pollCnt_d;
            lastR1_q   <= lastR1_d;
        end
    end

    // Registered port outputs, computed from the next state so each output
    // changes on the same edge as the state it belongs to. A/D are latched
    // on entry to SETUP and then held, so the requester may drop its inputs.
    always_ff @(posedge busclk_i) begin
        if (reset_i) begin
            spiA_q      <= 4'd0;
            spiD_q      <= 8'h00;
            isWr_q      <= 1'b0;
            nRd_q       <= 1'b1;
            nWr_q       <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= 8'h00;
            rdata1_q    <= 8'h00;
            status_q    <= 8'h00;
            statusChg_q <= 1'b0;
        end else begin
            if (state_d == SETUP) begin
                spiA_q <= selAddr;
                spiD_q <= selData;
                isWr_q <= selWr;
            end
            nRd_q   <= !((state_d == STROBE) && !isWr_q);
            nWr_q   <= !((state_d == STROBE) && isWr_q);
            gnt0_q  <= (state_d != IDLE) && (owner_d == OWN_R0);
            gnt1_q  <= (state_d != IDLE) && (owner_d == OWN_R1);
            done0_q <= strobeLast && (owner_q == OWN_R0);
            done1_q <= strobeLast && (owner_q == OWN_R1);
            if (strobeLast && (owner_q == OWN_R0) && !isWr_q) begin
                rdata0_q <= spi_D_i;
            end
            if (strobeLast && (owner_q == OWN_R1) && !isWr_q) begin
                rdata1_q <= spi_D_i;
            end
            if (strobeLast && (owner_q == OWN_POLL)) begin
                status_q    <= spi_D_i;
                statusChg_q <= (spi_D_i != status_q);
            end else begin
                statusChg_q <= 1'b0;
            end
        end
    end

    assign r0_gnt_o     = gnt0_q;
    assign r1_gnt_o     = gnt1_q;
    assign r0_done_o    = done0_q;
    assign r1_done_o    = done1_q;
    assign r0_rdata_o   = rdata0_q;
    assign r1_rdata_o   = rdata1_q;
    assign spi_A_o      = spiA_q;
    assign spi_D_o      = spiD_q;
    assign spi_nRD_o    = nRd_q;
    assign spi_nWR_o    = nWr_q;
    assign status_o     = status_q;
    assign status_chg_o = statusChg_q;

endmodule

// File: tb/tb_spi_port_arbiter.sv
// Testbench for spi_port_arbiter: directed scenarios with literal
// expectations followed by randomized requester traffic, all checked
// every cycle against a transaction-level model of the port.

module tb_spi_port_arbiter;

    localparam int S  = 2;
    localparam int R  = 1;
    localparam int PD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       req   [2];
    logic       wr    [2];
    logic [3:0] addr  [2];
    logic [7:0] wdata [2];
    logic       lock  [2];
    logic [7:0] spiDin;

    logic       r0_gnt_o, r0_done_o, r1_gnt_o, r1_done_o;
    logic [7:0] r0_rdata_o, r1_rdata_o;
    logic [3:0] spi_A_o;
    logic [7:0] spi_D_o;
    logic       spi_nRD_o, spi_nWR_o;
    logic [7:0] status_o;
    logic       status_chg_o;

    int checks = 0;
    int errors = 0;

    spi_port_arbiter #(.STROBE_CYC(S), .RECOVER_CYC(R), .POLL_DIV(PD)) dut (
        .busclk_i    (clock),
        .reset_i     (reset),
        .r0_req_i    (req[0]),
        .r0_wr_i     (wr[0]),
        .r0_addr_i   (addr[0]),
        .r0_wdata_i  (wdata[0]),
        .r0_lock_i   (lock[0]),
        .r0_gnt_o    (r0_gnt_o),
        .r0_done_o   (r0_done_o),
        .r0_rdata_o  (r0_rdata_o),
        .r1_req_i    (req[1]),
        .r1_wr_i     (wr[1]),
        .r1_addr_i   (addr[1]),
        .r1_wdata_i  (wdata[1]),
        .r1_lock_i   (lock[1]),
        .r1_gnt_o    (r1_gnt_o),
        .r1_done_o   (r1_done_o),
        .r1_rdata_o  (r1_rdata_o),
        .spi_A_o     (spi_A_o),
        .spi_D_o     (spi_D_o),
        .spi_D_i     (spiDin),
        .spi_nRD_o   (spi_nRD_o),
        .spi_nWR_o   (spi_nWR_o),
        .status_o    (status_o),
        .status_chg_o(status_chg_o)
    );

    // Free-running bus clock.
    always #5 clock = ~clock;

    // Transaction-level model. An access is described by its owner and the
    // number of cycles since its SETUP cycle (mPos): strobe cycles are
    // 1..S, done appears at S+1, and the port is released after S+R.
    bit         modelValid = 0;
    bit         mBusy;
    bit         mFresh;
    int         mPos;
    int         mOwner;
    int         mLast;
    int         mPollCnt;
    logic       mWr;
    logic [3:0] mAddr;
    logic [7:0] mData;
    logic       mDone  [2];
    logic [7:0] mRdata [2];
    logic [7:0] mStatus;
    logic       mChg;

    task automatic modelStart(input int who);
        mBusy  = 1;
        mFresh = 0;
        mPos   = 0;
        mOwner = who;
        if (who == 2) begin
            mWr   = 1'b0;
            mAddr = 4'd1;
        end else begin
            mWr   = wr[who];
            mAddr = addr[who];
            mData = wdata[who];
        end
    endtask

    // Model update on every rising edge, using the inputs present at it.
    always @(posedge clock) begin
        modelValid = 1;
        if (reset) begin
            mBusy = 0; mFresh = 1; mPos = 0; mOwner = 0; mLast = 1; mPollCnt = 0;
            mWr = 1'b0; mAddr = 4'd0; mData = 8'h00;
            mDone[0] = 1'b0; mDone[1] = 1'b0;
            mRdata[0] = 8'h00; mRdata[1] = 8'h00;
            mStatus = 8'h00; mChg = 1'b0;
        end else begin
            mDone[0] = 1'b0;
            mDone[1] = 1'b0;
            mChg     = 1'b0;
            if (mBusy) begin
                if (mPos == S + R) begin
                    if (mOwner < 2 && lock[mOwner] && req[mOwner]) modelStart(mOwner);
                    else mBusy = 0;
                end else begin
                    mPos++;
                    if (mPos == S + 1) begin
                        if (mOwner == 2) begin
                            mChg    = (spiDin != mStatus);
                            mStatus = spiDin;
                        end else begin
                            mDone[mOwner] = 1'b1;
                            if (!mWr) mRdata[mOwner] = spiDin;
                        end
                    end
                end
            end else if (req[0] || req[1]) begin
                int who;
                who = (req[0] && req[1]) ? (1 - mLast) : (req[0] ? 0 : 1);
                mLast = who;
                mPollCnt = 0;
                modelStart(who);
            end else if (mPollCnt == PD - 1) begin
                mPollCnt = 0;
                modelStart(2);
            end else begin
                mPollCnt++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int n, input logic rq, input logic w,
                                 input logic [3:0] a, input logic [7:0] d, input logic lk);
        req[n]   = rq;
        wr[n]    = w;
        addr[n]  = a;
        wdata[n] = d;
        lock[n]  = lk;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    logic [6:0] expCtl;
    always @(negedge clock) begin
        if (modelValid) begin
            expCtl = {mBusy && mOwner == 0, mBusy && mOwner == 1, mDone[0], mDone[1],
                      !(mBusy && mPos >= 1 && mPos <= S && !mWr),
                      !(mBusy && mPos >= 1 && mPos <= S && mWr), mChg};
            checkOutput("ctl{gnt0,gnt1,done0,done1,nRD,nWR,chg}",
                        {r0_gnt_o, r1_gnt_o, r0_done_o, r1_done_o, spi_nRD_o, spi_nWR_o, status_chg_o},
                        expCtl);
            if (mBusy || mFresh) checkOutput("spi_A", spi_A_o, mAddr);
            if ((mBusy && mWr) || mFresh) checkOutput("spi_D", spi_D_o, mData);
            checkOutput("r0_rdata", r0_rdata_o, mRdata[0]);
            checkOutput("r1_rdata", r1_rdata_o, mRdata[1]);
            checkOutput("status", status_o, mStatus);
        end
    end

    int         order [4] = '{0, 1, 0, 1};
    logic       prevG0, prevG1;
    int         grants;
    bit         found;

    initial begin
        reset = 1'b1;
        spiDin = 8'h00;
        applyStimulus(0, 0, 0, 4'd0, 8'h00, 0);
        applyStimulus(1, 0, 0, 4'd0, 8'h00, 0);
        waitCycles(3);

        $display("[TB] reset values");
        checkOutput("rst_nRD", spi_nRD_o, 1);
        checkOutput("rst_nWR", spi_nWR_o, 1);
        checkOutput("rst_A", spi_A_o, 0);
        checkOutput("rst_D", spi_D_o, 0);
        checkOutput("rst_gnt", {r0_gnt_o, r1_gnt_o, r0_done_o, r1_done_o}, 0);
        checkOutput("rst_rdata", {r0_rdata_o, r1_rdata_o}, 0);
        checkOutput("rst_status", {status_o, 7'd0, status_chg_o}, 0);

        $display("[TB] r0 write A5 to addr 0");
        reset = 1'b0;
        applyStimulus(0, 1, 1, 4'd0, 8'hA5, 0);
        waitCycles(1);
        checkOutput("wr_setup_gnt0", r0_gnt_o, 1);
        checkOutput("wr_setup_nWR", spi_nWR_o, 1);
        for (int c = 2; c <= 3; c++) begin
            waitCycles(1);
            checkOutput($sformatf("wr_strobe%0d_nWR", c), spi_nWR_o, 0);
            checkOutput($sformatf("wr_strobe%0d_nRD", c), spi_nRD_o, 1);
            checkOutput($sformatf("wr_strobe%0d_A", c), spi_A_o, 4'd0);
            checkOutput($sformatf("wr_strobe%0d_D", c), spi_D_o, 8'hA5);
        end
        waitCycles(1);
        checkOutput("wr_done0", r0_done_o, 1);
        checkOutput("wr_recover_nWR", spi_nWR_o, 1);
        checkOutput("wr_recover_gnt0", r0_gnt_o, 1);
        applyStimulus(0, 0, 1, 4'd0, 8'hA5, 0);
        waitCycles(1);
        checkOutput("wr_after_gnt0", r0_gnt_o, 0);
        checkOutput("wr_after_done0", r0_done_o, 0);

        $display("[TB] r1 read of addr 1 returning 3C");
        spiDin = 8'h3C;
        applyStimulus(1, 1, 0, 4'd1, 8'h00, 0);
        waitCycles(1);
        checkOutput("rd_setup_gnt1", r1_gnt_o, 1);
        for (int c = 2; c <= 3; c++) begin
            waitCycles(1);
            checkOutput($sformatf("rd_strobe%0d_nRD", c), spi_nRD_o, 0);
            checkOutput($sformatf("rd_strobe%0d_A", c), spi_A_o, 4'd1);
            checkOutput($sformatf("rd_strobe%0d_r0", c), {r0_gnt_o, r0_done_o}, 0);
        end
        waitCycles(1);
        checkOutput("rd_done1", r1_done_o, 1);
        checkOutput("rd_rdata1", r1_rdata_o, 8'h3C);
        checkOutput("rd_model_rdata1", mRdata[1], 8'h3C);
        checkOutput("rd_r0_quiet", {r0_gnt_o, r0_done_o, r0_rdata_o}, 0);
        applyStimulus(1, 0, 0, 4'd1, 8'h00, 0);
        waitCycles(2);

        $display("[TB] contention after reset");
        reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        applyStimulus(0, 1, 1, 4'd0, 8'h11, 0);
        applyStimulus(1, 1, 1, 4'd0, 8'h22, 0);
        grants = 0;
        prevG0 = 1'b0;
        prevG1 = 1'b0;
        for (int i = 0; i < 60 && grants < 4; i++) begin
            waitCycles(1);
            checkOutput("gnt_exclusive", r0_gnt_o & r1_gnt_o, 0);
            if ((r0_gnt_o && !prevG0) || (r1_gnt_o && !prevG1)) begin
                checkOutput($sformatf("grant_order%0d", grants), r1_gnt_o ? 1 : 0, order[grants]);
                grants++;
            end
            prevG0 = r0_gnt_o;
            prevG1 = r1_gnt_o;
        end
        checkOutput("contention_grants", grants, 4);
        applyStimulus(0, 0, 1, 4'd0, 8'h11, 0);
        applyStimulus(1, 0, 1, 4'd0, 8'h22, 0);
        waitCycles(6);

        $display("[TB] r1 locked burst of four writes against r0");
        applyStimulus(1, 1, 1, 4'd0, 8'hB0, 1);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            waitCycles(1);
            if (r1_gnt_o === 1'b1) found = 1;
        end
        checkOutput("lock_first_gnt", found, 1);
        if (found) begin
            applyStimulus(0, 1, 0, 4'd0, 8'h00, 0);
            for (int i = 0; i < 16; i++) begin
                checkOutput($sformatf("burst_gnt1_%0d", i), r1_gnt_o, 1);
                checkOutput($sformatf("burst_gnt0_%0d", i), r0_gnt_o, 0);
                checkOutput($sformatf("burst_done1_%0d", i), r1_done_o, (i % 4 == 3));
                if (i == 15) applyStimulus(1, 0, 1, 4'd0, 8'h00, 0);
                else if (i % 4 == 3) wdata[1] = 8'hB1 + 8'(i);
                waitCycles(1);
            end
            checkOutput("burst_idle_gnt", {r0_gnt_o, r1_gnt_o}, 0);
            waitCycles(1);
            checkOutput("burst_then_gnt0", r0_gnt_o, 1);
            waitCycles(3);
            checkOutput("burst_then_done0", r0_done_o, 1);
        end
        applyStimulus(0, 0, 0, 4'd0, 8'h00, 0);
        applyStimulus(1, 0, 0, 4'd0, 8'h00, 0);
        waitCycles(2);

        $display("[TB] status polling with value 81");
        reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        spiDin = 8'h81;
        waitCycles(4);
        checkOutput("poll_setup_A", spi_A_o, 4'd1);
        checkOutput("poll_setup_gnt", {r0_gnt_o, r1_gnt_o}, 0);
        waitCycles(1);
        checkOutput("poll_strobe_nRD", spi_nRD_o, 0);
        waitCycles(2);
        checkOutput("poll_status", status_o, 8'h81);
        checkOutput("poll_chg", status_chg_o, 1);
        checkOutput("poll_model_status", mStatus, 8'h81);
        for (int c = 8; c <= 20; c++) begin
            waitCycles(1);
            if (c <= 16) checkOutput($sformatf("poll_nochg_c%0d", c), status_chg_o, 0);
            if (c == 13) applyStimulus(0, 1, 0, 4'd0, 8'h00, 0);
            if (c == 14) checkOutput("poll2_nRD", spi_nRD_o, 0);
            if (c == 15) checkOutput("poll2_status", status_o, 8'h81);
            if (c == 16) checkOutput("poll_mid_idle_gnt0", r0_gnt_o, 0);
            if (c == 17) checkOutput("poll_then_gnt0", r0_gnt_o, 1);
            if (c == 20) begin
                checkOutput("poll_then_done0", r0_done_o, 1);
                checkOutput("poll_then_rdata0", r0_rdata_o, 8'h81);
                applyStimulus(0, 0, 0, 4'd0, 8'h00, 0);
            end
        end
        waitCycles(2);

        $display("[TB] reset during second strobe cycle of r0 write");
        reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        applyStimulus(0, 1, 1, 4'd0, 8'h5A, 0);
        waitCycles(3);
        checkOutput("abort_pre_nWR", spi_nWR_o, 0);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("abort_nWR", spi_nWR_o, 1);
        checkOutput("abort_gnt0", r0_gnt_o, 0);
        checkOutput("abort_done0", r0_done_o, 0);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("abort_retry_gnt0", r0_gnt_o, 1);
        for (int c = 6; c <= 8; c++) begin
            waitCycles(1);
            checkOutput($sformatf("abort_retry_done0_c%0d", c), r0_done_o, (c == 8));
        end
        applyStimulus(0, 0, 1, 4'd0, 8'h5A, 0);
        waitCycles(2);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            waitCycles(1);
            spiDin = 8'($urandom);
            reset = ($urandom_range(0, 700) == 0);
            for (int n = 0; n < 2; n++) begin
                if (req[n]) begin
                    if (mDone[n]) begin
                        if ($urandom_range(0, 3) == 0) req[n] = 1'b0;
                        else applyStimulus(n, 1, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
                    end else if ($urandom_range(0, 40) == 0) begin
                        req[n] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(n, 1, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
                end
            end
        end
        reset = 1'b0;
        applyStimulus(0, 0, 0, 4'd0, 8'h00, 0);
        applyStimulus(1, 0, 0, 4'd0, 8'h00, 0);
        waitCycles(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
